rom_read_arbiter: RTL and testbench

//  Shares the single-port sprite/glyph ROM (1 read/cycle, registered output) between two requesters:

---
 rtl/rom_read_arbiter_pkg.sv | 19 +
 rtl/rom_tag_pipe.sv | 36 +++
 rtl/rom_read_arbiter.sv | 114 +++++++++++
 tb/tb_rom_read_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_read_arbiter_pkg.sv
// Shared constants and types for the ROM read arbiter.
//   ROM_AW / ROM_DW : default ROM address / data widths
//   PORT_PIX        : owner id of the pixel renderer (high priority)
//   PORT_AUX        : owner id of the auxiliary reader
//   rom_tag_t       : {valid, owner} tag carried alongside each ROM read
package rom_read_arbiter_pkg;

   localparam int unsigned ROM_AW = 3;
   localparam int unsigned ROM_DW = 8;

   localparam logic PORT_PIX = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   typedef struct packed {
      logic valid;
      logic owner;
   } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Shift register of read tags that tracks each issued ROM read until its
// data appears on douta. Stage 0 is loaded on the edge that ends the
// grant cycle; the last stage lines up with the ROM output.
//   clk     : pixel clock
//   reset   : synchronous, active-high; drops every read in flight
//   tag_in  : tag of the read granted this cycle (valid=0 when idle)
//   tag_out : tag of the read whose data is on douta this cycle
module rom_tag_pipe
   import rom_read_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  rom_tag_t tag_in,
   output rom_tag_t tag_out
);

   rom_tag_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= tag_in;
         for (int unsigned i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares the single-port sprite/glyph ROM between the pixel renderer
// (port 0, fixed high priority) and an auxiliary reader (port 1). A
// starvation guard forces a port-1 grant after MAX_WAIT lost arbitrations.
//   clk, reset        : pixel clock, synchronous active-high reset
//   req0/addr0        : port-0 request and address (hold until gnt0)
//   gnt0              : port-0 request accepted this cycle
//   rvalid0/rdata0    : port-0 read data, one-cycle pulse per read
//   req1/addr1/gnt1/rvalid1/rdata1 : same for port 1
//   forced            : this cycle's gnt1 comes from the starvation guard
//   rom_addr          : registered address to ROM addra
//   rom_data          : ROM douta
module rom_read_arbiter
   import rom_read_arbiter_pkg::*;
#(
   parameter int unsigned AW       = ROM_AW,
   parameter int unsigned DW       = ROM_DW,
   parameter int unsigned ROM_LAT  = 1,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          forced,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data
);

   localparam int unsigned    WCW        = $clog2(MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

   logic [WCW-1:0] wait_cnt;
   logic           grant0;
   logic           grant1;
   logic           force_aux;
   rom_tag_t       tag_push;
   rom_tag_t       tag_head;

   // Grants are suppressed in the reset cycle so nothing is issued into a
   // pipeline that is being cleared on the same edge.
   always_comb begin
      grant0    = 1'b0;
      grant1    = 1'b0;
      force_aux = 1'b0;
      if (!reset) begin
         if (req1 && (wait_cnt == WAIT_LIMIT)) begin
            grant1    = 1'b1;
            force_aux = 1'b1;
         end else if (req0) begin
            grant0 = 1'b1;
         end else if (req1) begin
            grant1 = 1'b1;
         end
      end
   end

   assign gnt0   = grant0;
   assign gnt1   = grant1;
   assign forced = force_aux;

   // Counts consecutive cycles port 1 asked and lost; any gap in req1
   // (abandon) or a port-1 grant restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (!req1 || grant1) begin
         wait_cnt <= '0;
      end else if (wait_cnt != WAIT_LIMIT) begin
         wait_cnt <= wait_cnt + WCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rom_addr <= '0;
      end else if (grant0) begin
         rom_addr <= addr0;
      end else if (grant1) begin
         rom_addr <= addr1;
      end
   end

   always_comb begin
      tag_push       = '0;
      tag_push.valid = grant0 | grant1;
      tag_push.owner = grant1 ? PORT_AUX : PORT_PIX;
   end

   // One stage for the rom_addr register plus ROM_LAT for the ROM itself.
   rom_tag_pipe #(
      .DEPTH (1 + ROM_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_push),
      .tag_out (tag_head)
   );

   // Returns are masked during the reset cycle as well: the pipe only
   // clears on the edge that ends it.
   assign rvalid0 = !reset && tag_head.valid && (tag_head.owner == PORT_PIX);
   assign rvalid1 = !reset && tag_head.valid && (tag_head.owner == PORT_AUX);
   assign rdata0  = rvalid0 ? rom_data : '0;
   assign rdata1  = rvalid1 ? rom_data : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int NCYC     = 1024;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0, req1;
   logic [2:0] addr0, addr1;

   logic       gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, forced_a;
   logic [7:0] rdata0_a, rdata1_a, rom_data_a;
   logic [2:0] rom_addr_a;
   logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, forced_b;
   logic [7:0] rdata0_b, rdata1_b, rom_data_b, rom_pipe_b;
   logic [2:0] rom_addr_b;

   logic [7:0] mem [8];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   rom_read_arbiter #(
      .AW(3), .DW(8), .ROM_LAT(1), .MAX_WAIT(MAX_WAIT)
   ) dut_a (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rvalid0_a), .rdata0(rdata0_a),
      .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rvalid1(rvalid1_a), .rdata1(rdata1_a),
      .forced(forced_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a)
   );

   rom_read_arbiter #(
      .AW(3), .DW(8), .ROM_LAT(2), .MAX_WAIT(MAX_WAIT)
   ) dut_b (
      .clk(clk), .reset(reset),
      .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rvalid0_b), .rdata0(rdata0_b),
      .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rvalid1(rvalid1_b), .rdata1(rdata1_b),
      .forced(forced_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b)
   );

   // ROM contents: ROM[k] = 0x11 * (k+1), i.e. 11,22,...,88.
   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'(17 * (i + 1));
   end

   // Registered ROMs with latency 1 and 2.
   always @(posedge clk) begin
      rom_data_a <= mem[rom_addr_a];
      rom_pipe_b <= mem[rom_addr_b];
      rom_data_b <= rom_pipe_b;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   // Per-cycle history of what was granted; a read granted in cycle g
   // returns in cycle g+1+lat unless a reset cycle lies in between.
   int         cyc    = 0;
   bit         chk_en = 0;
   int         m_wait = 0;
   logic [2:0] m_addr = '0;
   bit         hv [NCYC];
   bit         ho [NCYC];
   logic [2:0] ha [NCYC];
   bit         hr [NCYC];

   function automatic void ret_exp(input int lat, output bit v0, output bit v1,
                                   output logic [7:0] d);
      int src;
      bit killed;
      src = cyc - 1 - lat;
      v0 = 0; v1 = 0; d = '0;
      killed = hr[cyc];
      if (src >= 0) begin
         for (int k = src + 1; k < cyc; k++) if (hr[k]) killed = 1;
         if (hv[src] && !killed) begin
            if (ho[src]) v1 = 1; else v0 = 1;
            d = mem[ha[src]];
         end
      end
   endfunction

   always @(negedge clk) begin
      bit ef, e0, e1, v0, v1;
      logic [7:0] d;
      ef = !reset && req1 && (m_wait == MAX_WAIT);
      e0 = !reset && req0 && !ef;
      e1 = !reset && req1 && !e0;
      hv[cyc] = e0 || e1;
      ho[cyc] = e1;
      ha[cyc] = e1 ? addr1 : addr0;
      hr[cyc] = reset;
      if (chk_en) begin
         chk("m_gnt0_a", 32'(gnt0_a), 32'(e0));
         chk("m_gnt1_a", 32'(gnt1_a), 32'(e1));
         chk("m_forced_a", 32'(forced_a), 32'(ef));
         chk("m_rom_addr_a", 32'(rom_addr_a), 32'(m_addr));
         chk("m_gnt0_b", 32'(gnt0_b), 32'(e0));
         chk("m_gnt1_b", 32'(gnt1_b), 32'(e1));
         chk("m_forced_b", 32'(forced_b), 32'(ef));
         chk("m_rom_addr_b", 32'(rom_addr_b), 32'(m_addr));
         ret_exp(1, v0, v1, d);
         chk("m_rvalid0_a", 32'(rvalid0_a), 32'(v0));
         chk("m_rvalid1_a", 32'(rvalid1_a), 32'(v1));
         chk("m_rdata0_a", 32'(rdata0_a), v0 ? 32'(d) : 32'd0);
         chk("m_rdata1_a", 32'(rdata1_a), v1 ? 32'(d) : 32'd0);
         ret_exp(2, v0, v1, d);
         chk("m_rvalid0_b", 32'(rvalid0_b), 32'(v0));
         chk("m_rvalid1_b", 32'(rvalid1_b), 32'(v1));
         chk("m_rdata0_b", 32'(rdata0_b), v0 ? 32'(d) : 32'd0);
         chk("m_rdata1_b", 32'(rdata1_b), v1 ? 32'(d) : 32'd0);
      end
      if (reset) chk_en = 1;
      if (reset || !req1 || e1) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      if (reset) m_addr = '0;
      else if (e0) m_addr = addr0;
      else if (e1) m_addr = addr1;
      if (cyc < NCYC - 1) cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic drive(input bit r0, input int a0, input bit r1, input int a1, input bit rst);
      @(posedge clk);
      #1;
      req0  = r0;
      addr0 = 3'(a0);
      req1  = r1;
      addr1 = 3'(a1);
      reset = rst;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      drive(0, 0, 0, 0, 1);
      @(negedge clk);
      chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
      chk("rst_rvalid0", 32'(rvalid0_a), 32'd0);
      idle(2);

      // single port-0 read of address 3
      drive(1, 3, 0, 0, 0);
      @(negedge clk);
      chk("t1_gnt0", 32'(gnt0_a), 32'd1);
      chk("t1_gnt1", 32'(gnt1_a), 32'd0);
      idle(1);
      @(negedge clk);
      chk("t1_rom_addr", 32'(rom_addr_a), 32'd3);
      chk("t1_rvalid0_early", 32'(rvalid0_a), 32'd0);
      idle(1);
      @(negedge clk);
      chk("t1_rvalid0", 32'(rvalid0_a), 32'd1);
      chk("t1_rdata0", 32'(rdata0_a), 32'h44);
      chk("t1_rvalid1", 32'(rvalid1_a), 32'd0);
      chk("t6_rvalid0_b_early", 32'(rvalid0_b), 32'd0);
      idle(1);
      @(negedge clk);
      chk("t6_rvalid0_b", 32'(rvalid0_b), 32'd1);
      chk("t6_rdata0_b", 32'(rdata0_b), 32'h44);
      chk("t6_rvalid0_a_done", 32'(rvalid0_a), 32'd0);
      idle(3);

      // both ports held: 4:1 pattern, addr1 changes while waiting
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 1, i % 8, 0);
         @(negedge clk);
         chk("t2_gnt1", 32'(gnt1_a), (i % 5 == 4) ? 32'd1 : 32'd0);
         chk("t2_forced", 32'(forced_a), (i % 5 == 4) ? 32'd1 : 32'd0);
         chk("t2_gnt0", 32'(gnt0_a), (i % 5 == 4) ? 32'd0 : 32'd1);
      end
      idle(4);

      // port 1 abandons after two losses; its wait count restarts
      drive(1, 0, 1, 3, 0);
      drive(1, 0, 1, 3, 0);
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, i, 0);
         @(negedge clk);
         chk("ab_gnt1", 32'(gnt1_a), (i == 4) ? 32'd1 : 32'd0);
      end
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("ab_rom_addr", 32'(rom_addr_a), 32'd4);
      idle(4);

      // back-to-back reads of addresses 0..7
      for (int i = 0; i < 8; i++) begin
         drive(1, i, 0, 0, 0);
         @(negedge clk);
         chk("t3_gnt0", 32'(gnt0_a), 32'd1);
         if (i >= 2) begin
            chk("t3_rvalid0", 32'(rvalid0_a), 32'd1);
            chk("t3_rdata0", 32'(rdata0_a), 32'(8'(17 * (i - 1))));
         end
      end
      idle(5);

      // port 1 alone
      drive(0, 0, 1, 5, 0);
      @(negedge clk);
      chk("t4_gnt1", 32'(gnt1_a), 32'd1);
      chk("t4_forced", 32'(forced_a), 32'd0);
      idle(1);
      idle(1);
      @(negedge clk);
      chk("t4_rvalid1", 32'(rvalid1_a), 32'd1);
      chk("t4_rdata1", 32'(rdata1_a), 32'h66);
      chk("t4_rvalid0", 32'(rvalid0_a), 32'd0);
      idle(4);

      // reset right after grants: in-flight reads dropped
      drive(1, 1, 0, 0, 0);
      drive(1, 2, 0, 0, 0);
      drive(1, 6, 1, 6, 1);
      @(negedge clk);
      chk("t5_gnt0", 32'(gnt0_a), 32'd0);
      chk("t5_gnt1", 32'(gnt1_a), 32'd0);
      chk("t5_forced", 32'(forced_a), 32'd0);
      chk("t5_rvalid0", 32'(rvalid0_a), 32'd0);
      chk("t5_rdata0", 32'(rdata0_a), 32'd0);
      chk("t5_rvalid1", 32'(rvalid1_a), 32'd0);
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 0);
         @(negedge clk);
         chk("t5_post_rvalid0_a", 32'(rvalid0_a), 32'd0);
         chk("t5_post_rvalid0_b", 32'(rvalid0_b), 32'd0);
         chk("t5_post_rom_addr", 32'(rom_addr_a), 32'd0);
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
